led_sched_ctrl: RTL and testbench

//   Configurable LED controller for N_LED outputs driven from one shared prescaler tick.
//   A valid/ready command port selects a per-channel mode: OFF, ON, BLINK or one-shot PULSE.

---
 rtl/led_pkg.sv | 18 +
 rtl/led_tick_gen.sv | 26 ++
 rtl/led_sched_ctrl.sv | 152 +++++++++++++++
 tb/tb_led_sched_ctrl.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED scheduler: channel modes, command FSM states and widths.
package led_pkg;

    localparam int MODE_W = 2;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PULSE = 2'd3
    } led_mode_t;

    typedef enum logic {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } cmd_state_t;

endpackage

// File: rtl/led_tick_gen.sv
// Shared prescaler: one-cycle tick every PRESCALE clk cycles (PRESCALE of 0 or 1 ticks every cycle).
module led_tick_gen #(
    parameter logic [31:0] PRESCALE = 32'd4
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam logic [31:0] PS_EFF = (PRESCALE <= 32'd1) ? 32'd1 : PRESCALE;

    logic [31:0] pre_cnt;

    assign tick = (pre_cnt == (PS_EFF - 32'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_cnt <= '0;
        end else if (tick) begin
            pre_cnt <= '0;
        end else begin
            pre_cnt <= pre_cnt + 32'd1;
        end
    end

endmodule

// File: rtl/led_sched_ctrl.sv
// Multi-channel LED controller with OFF/ON/BLINK/PULSE modes driven by one shared tick.
// Optional per-channel PWM brightness is enabled by defining LED_PWM_EN.
module led_sched_ctrl
    import led_pkg::*;
#(
    parameter int          N_LED    = 4,
    parameter int          CNT_W    = 32,
    parameter logic [31:0] PRESCALE = 32'd4,
    parameter int          PWM_W    = 4,
    localparam int         IDX_W    = (N_LED > 1) ? $clog2(N_LED) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [MODE_W-1:0] cfg_mode,
    input  logic [CNT_W-1:0]  cfg_half,
`ifdef LED_PWM_EN
    input  logic [PWM_W-1:0]  cfg_duty,
`endif
    output logic [N_LED-1:0]  led,
    output logic [N_LED-1:0]  pulse_done
);

    cmd_state_t state_q;
    cmd_state_t state_d;
    logic       tick;
    logic       accept;
    led_mode_t  new_mode;
    logic [CNT_W-1:0] new_half;

    led_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign accept   = cfg_valid && cfg_ready;
    assign new_mode = led_mode_t'(cfg_mode);
    assign new_half = (cfg_half == '0) ? CNT_W'(1) : cfg_half;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cfg_valid) state_d = APPLY;
            APPLY:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cfg_ready = (state_q == IDLE);
    end

`ifdef LED_PWM_EN
    logic [PWM_W-1:0] pwm_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
        end
    end
`endif

    for (genvar i = 0; i < N_LED; i++) begin : g_ch
        led_mode_t        mode_q;
        logic [CNT_W-1:0] cnt_q;
        logic [CNT_W-1:0] half_q;
        logic             led_q;
        logic             done_q;
        logic             hit;
        logic             at_end;

        // An out-of-range index matches no channel, so such commands are accepted but ignored.
        assign hit    = accept && (cfg_idx == IDX_W'(i));
        assign at_end = (cnt_q >= (half_q - CNT_W'(1)));

        // The command takes priority over a coincident tick; that tick is simply lost for this channel.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                mode_q <= MODE_OFF;
                cnt_q  <= '0;
                half_q <= CNT_W'(1);
                led_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                done_q <= 1'b0;
                if (hit) begin
                    mode_q <= new_mode;
                    cnt_q  <= '0;
                    half_q <= new_half;
                    led_q  <= (new_mode != MODE_OFF);
                end else if (tick) begin
                    case (mode_q)
                        MODE_BLINK: begin
                            if (at_end) begin
                                cnt_q <= '0;
                                led_q <= ~led_q;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        MODE_PULSE: begin
                            if (at_end) begin
                                cnt_q  <= '0;
                                led_q  <= 1'b0;
                                mode_q <= MODE_OFF;
                                done_q <= 1'b1;
                            end else begin
                                cnt_q <= cnt_q + CNT_W'(1);
                            end
                        end
                        default: cnt_q <= '0;
                    endcase
                end
            end
        end

        assign pulse_done[i] = done_q;

`ifdef LED_PWM_EN
        logic [PWM_W-1:0] duty_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                duty_q <= '1;
            end else if (hit) begin
                duty_q <= cfg_duty;
            end
        end

        // Full-scale duty bypasses the comparator so the LED is steadily on.
        assign led[i] = led_q & ((duty_q == '1) | (pwm_cnt < duty_q));
`else
        assign led[i] = led_q;
`endif
    end

endmodule

// File: tb/tb_led_sched_ctrl.sv
// Self-checking bench for led_sched_ctrl: directed and random commands against a tick-count reference model.
`timescale 1ns/1ps
module tb_led_sched_ctrl;

    localparam int N   = 4;
    localparam int P   = 4;
    localparam int PWM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_idx;
    logic [1:0]  cfg_mode;
    logic [31:0] cfg_half;
    logic [3:0]  cfg_duty;
    logic [N-1:0] led;
    logic [N-1:0] pulse_done;

    logic        valid3;
    logic        ready3;
    logic [1:0]  idx3;
    logic [2:0]  led3;
    logic [2:0]  done3;

    int compareCount = 0;
    int failCount    = 0;

    int mMode [N];
    int mHalf [N];
    int mEl   [N];
    bit mLed  [N];
    bit mDone [N];
    int mDuty [N];
    bit mReady;
    bit m3Ready;
    int mK;

    always #5 clk = ~clk;

    led_sched_ctrl #(.N_LED(N), .CNT_W(32), .PRESCALE(32'd4), .PWM_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_idx   (cfg_idx),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
`ifdef LED_PWM_EN
        .cfg_duty  (cfg_duty),
`endif
        .led       (led),
        .pulse_done(pulse_done)
    );

    led_sched_ctrl #(.N_LED(3), .CNT_W(32), .PRESCALE(32'd4), .PWM_W(4)) dut3 (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (valid3),
        .cfg_ready (ready3),
        .cfg_idx   (idx3),
        .cfg_mode  (cfg_mode),
        .cfg_half  (cfg_half),
`ifdef LED_PWM_EN
        .cfg_duty  (cfg_duty),
`endif
        .led       (led3),
        .pulse_done(done3)
    );

    task automatic resetModel();
        for (int i = 0; i < N; i++) begin
            mMode[i] = 0; mHalf[i] = 1; mEl[i] = 0;
            mLed[i] = 0; mDone[i] = 0; mDuty[i] = 15;
        end
        mReady  = 1;
        m3Ready = 1;
        mK      = 0;
    endtask

    // Channel state is derived from ticks elapsed since the last command.
    task automatic modelEdge();
        bit tick;
        bit acc;
        tick = ((mK % P) == (P - 1));
        acc  = cfg_valid && mReady;
        for (int i = 0; i < N; i++) begin
            mDone[i] = 0;
            if (acc && (int'(cfg_idx) == i)) begin
                mMode[i] = int'(cfg_mode);
                mHalf[i] = (cfg_half == 0) ? 1 : int'(cfg_half);
                mEl[i]   = 0;
                mLed[i]  = (cfg_mode != 2'd0);
                mDuty[i] = int'(cfg_duty);
            end else if (tick) begin
                if (mMode[i] == 2) begin
                    mEl[i]++;
                    mLed[i] = (((mEl[i] / mHalf[i]) % 2) == 0);
                end else if (mMode[i] == 3) begin
                    mEl[i]++;
                    if (mEl[i] >= mHalf[i]) begin
                        mLed[i]  = 0;
                        mMode[i] = 0;
                        mDone[i] = 1;
                    end
                end
            end
        end
        mReady  = !acc;
        m3Ready = !(valid3 && m3Ready);
        mK++;
    endtask

    task automatic applyStimulus(input bit v, input int idx, input int mode, input int half, input int duty);
        cfg_valid = v;
        cfg_idx   = 2'(idx);
        cfg_mode  = 2'(mode);
        cfg_half  = 32'(half);
        cfg_duty  = 4'(duty);
    endtask

    task automatic checkOutput();
        logic [N-1:0] expLed;
        logic [N-1:0] expDone;
        for (int i = 0; i < N; i++) begin
            bit on;
            on = mLed[i];
`ifdef LED_PWM_EN
            on = on && ((mDuty[i] == 15) || ((mK % PWM) < mDuty[i]));
`endif
            expLed[i]  = on;
            expDone[i] = mDone[i];
        end
        compareCount++;
        assert (led === expLed) else begin
            failCount++;
            $error("[TB] FAIL led: observed %b expected %b at edge %0d", led, expLed, mK);
        end
        compareCount++;
        assert (pulse_done === expDone) else begin
            failCount++;
            $error("[TB] FAIL pulse_done: observed %b expected %b at edge %0d", pulse_done, expDone, mK);
        end
        compareCount++;
        assert (cfg_ready === mReady) else begin
            failCount++;
            $error("[TB] FAIL cfg_ready: observed %b expected %b at edge %0d", cfg_ready, mReady, mK);
        end
        compareCount++;
        assert (ready3 === m3Ready) else begin
            failCount++;
            $error("[TB] FAIL ready3: observed %b expected %b at edge %0d", ready3, m3Ready, mK);
        end
        compareCount++;
        assert ({led3, done3} === 6'b0) else begin
            failCount++;
            $error("[TB] FAIL ignored_idx: observed led3=%b done3=%b expected 000/000", led3, done3);
        end
    endtask

    task automatic runCycles(input int n);
        for (int c = 0; c < n; c++) begin
            if (!rst) modelEdge();
            @(posedge clk);
            #1;
            checkOutput();
        end
    endtask

    task automatic sendCmd(input int idx, input int mode, input int half, input int duty);
        applyStimulus(1'b1, idx, mode, half, duty);
        runCycles(1);
        applyStimulus(1'b0, 0, 0, 0, 15);
    endtask

    initial begin
        rst = 1'b1;
        valid3 = 1'b0;
        idx3 = 2'd3;
        applyStimulus(1'b0, 0, 0, 0, 15);
        resetModel();

        $display("[TB] reset hold");
        runCycles(3);
        rst = 1'b0;
        runCycles(10);

        $display("[TB] blink ch0 half=2");
        sendCmd(0, 2, 2, 15);
        runCycles(40);

        $display("[TB] pulse ch1 half=3");
        sendCmd(1, 3, 3, 15);
        runCycles(30);

        $display("[TB] blink ch2 half=0 and out-of-range index");
        sendCmd(2, 2, 0, 15);
        runCycles(6);
        valid3 = 1'b1;
        runCycles(1);
        valid3 = 1'b0;
        runCycles(14);

        $display("[TB] accept on tick cycle");
        sendCmd(1, 2, 3, 15);
        runCycles(7);
        for (int w = 0; w < P && (mK % P) != (P - 1); w++) runCycles(1);
        sendCmd(0, 2, 2, 15);
        runCycles(40);

`ifdef LED_PWM_EN
        $display("[TB] pwm duty sweep on ch3");
        sendCmd(3, 1, 1, 4);
        runCycles(32);
        sendCmd(3, 1, 1, 15);
        runCycles(20);
        sendCmd(3, 1, 1, 0);
        runCycles(20);
`endif

        $display("[TB] random commands");
        for (int r = 0; r < 400; r++) begin
            applyStimulus(($urandom_range(0, 3) == 0), $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 4), $urandom_range(0, 15));
            valid3 = ($urandom_range(0, 7) == 0);
            runCycles(1);
        end
        applyStimulus(1'b0, 0, 0, 0, 15);
        valid3 = 1'b0;
        runCycles(4);

        $display("[TB] reset mid-pulse");
        sendCmd(3, 3, 5, 15);
        runCycles(6);
        #2;
        rst = 1'b1;
        #1;
        compareCount++;
        assert (led === 4'b0) else begin
            failCount++;
            $error("[TB] FAIL async_reset_led: observed %b expected 0000", led);
        end
        compareCount++;
        assert (pulse_done === 4'b0) else begin
            failCount++;
            $error("[TB] FAIL async_reset_done: observed %b expected 0000", pulse_done);
        end
        resetModel();
        runCycles(2);
        rst = 1'b0;
        runCycles(30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
